tiny_decryption_algorithm: RTL and testbench
============================================

TINY_DECRYPTION_ALGORITHM -- requirements
Module: tiny_decryption_algorithm

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 key_valid  input  1  1 = key stable and valid, 0 = otherwise.
REQ-005 ctxt_valid  input  1  1 = ctxt_blk stable and valid, 0 = otherwise.
REQ-006 ctxt_blk  input  64  ciphertext block; v0 = [63:32], v1 = [31:0].
REQ-007 key  input  128  key; k0 = [127:96], k1 = [95:64], k2 = [63:32], k3 = [31:0].
REQ-008 ptxt_blk  output  64  recovered plaintext, registered; v0 in [63:32], v1 in [31:0].
REQ-009 ptxt_ready  output  1  registered; 1 = ptxt_blk stable and valid, 0 = otherwise.

Function
REQ-010 The block SHALL be an iterative TEA decryptor with three states: IDLE, RUN and DONE.
REQ-011 IDLE: at a rising edge with ctxt_valid=1 and key_valid=1, the block SHALL capture ctxt_blk and key, load sum=32'hC6EF3720, clear round counter to 0 and go to RUN.
REQ-012 RUN: each rising edge SHALL perform one round, all arithmetic mod 2^32:
- v1 -= ((v0<<4)+k2) ^ (v0+sum) ^ ((v0>>5)+k3), logical shifts
- then v0 -= ((new v1<<4)+k0) ^ (new v1+sum) ^ ((new v1>>5)+k1)
- then sum -= 32'h9E3779B9 and counter += 1
REQ-013 On the edge performing round 32 (counter 31 to 32), the block SHALL register the result into ptxt_blk, set ptxt_ready=1 and go to DONE; latency is 32 clocks after the capture edge.
REQ-014 DONE: ptxt_blk and ptxt_ready=1 SHALL hold while ctxt_valid=1 and key_valid=1.
REQ-015 DONE: at the first edge where either valid is 0, the block SHALL clear ptxt_ready and go to IDLE; ptxt_blk keeps its last value.
REQ-016 RUN: if either valid is 0 at an edge, the block SHALL abort to IDLE, leave ptxt_ready=0 and leave ptxt_blk unchanged.
REQ-017 Inputs SHALL be ignored in RUN except for their valid bits; a change to ctxt_blk or key during RUN does not affect the result.
REQ-018 A new decryption SHALL start only from IDLE, so back-to-back blocks require the valids to drop for at least one edge.
REQ-019 The counter SHALL be 6 bits and SHALL NOT wrap during RUN; a counter value above 32 SHALL NOT be reachable.
REQ-020 After a full decryption, the sum register SHALL equal 0 (self-check, assertion in simulation).

Reset
REQ-021 rst_n=0 SHALL immediately set state=IDLE, ptxt_ready=0, ptxt_blk=64'h0, sum=0 and counter=0, including in the middle of RUN or DONE.
REQ-022 After rst_n deasserts, the first capture SHALL occur no earlier than the first rising edge with rst_n=1 and both valids=1.

Structure
REQ-023 Package tea_pkg SHALL hold DELTA=32'h9E3779B9, DEC_SUM_INIT=32'hC6EF3720, NUM_ROUNDS=32 and the state enum typedef.
REQ-024 One combinational sub-module, tea_round_dec, SHALL compute a single decryption round from (v0, v1, sum, key) to (v0', v1').

Verification
REQ-025 key=128'h8000...0 and ctxt=64'h9327C49731B08BBE with both valids held -> ptxt_ready rises 32 clocks after capture and ptxt_blk=64'h0.
REQ-026 key=0 and ctxt=64'h41EA3A0A94BAA940 -> ptxt_blk=64'h0000000000000000 and ptxt_ready=1.
REQ-027 Valid combinations 0/0, 1/0 and 0/1 held for 40 clocks -> ptxt_ready stays 0 throughout.
REQ-028 ctxt_valid drops at round 10 -> abort to IDLE, ptxt_ready is never 1 and ptxt_blk is unchanged.
REQ-029 rst_n pulsed low at round 20 -> outputs are 0 immediately; a subsequent full run of REQ-025 passes.
REQ-030 In DONE, drop key_valid for one edge and then reassert both valids -> ptxt_ready falls, a new 32-clock run follows and ptxt_ready rises again.

Source files
------------

// File: rtl/tea_pkg.sv
// ============================================================================
// tea_pkg : shared constants and state type for the TEA decryptor
// Revision: 1.0
// ============================================================================
`default_nettype none

package tea_pkg;

    localparam logic [31:0] DELTA        = 32'h9E3779B9;
    localparam logic [31:0] DEC_SUM_INIT = 32'hC6EF3720;
    localparam int unsigned NUM_ROUNDS   = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } tea_state_t;

endpackage

`default_nettype wire

// File: rtl/tea_round_dec.sv
// ============================================================================
// tea_round_dec : one combinational TEA decryption round
// Revision: 1.0
// ============================================================================
`default_nettype none

module tea_round_dec (
    input  logic [31:0]  v0,
    input  logic [31:0]  v1,
    input  logic [31:0]  sum,
    input  logic [127:0] key,
    output logic [31:0]  v0_next,
    output logic [31:0]  v1_next
);

    logic [31:0] k0, k1, k2, k3;

    assign k0 = key[127:96];
    assign k1 = key[95:64];
    assign k2 = key[63:32];
    assign k3 = key[31:0];

    // v1 is undone first; v0 then uses the freshly recovered v1
    assign v1_next = v1 - (((v0 << 4) + k2) ^ (v0 + sum) ^ ((v0 >> 5) + k3));
    assign v0_next = v0 - (((v1_next << 4) + k0) ^ (v1_next + sum) ^ ((v1_next >> 5) + k1));

endmodule

`default_nettype wire

// File: rtl/tiny_decryption_algorithm.sv
// ============================================================================
// tiny_decryption_algorithm : iterative 32-round TEA block decryptor
// Revision: 1.0
// ============================================================================
`default_nettype none

module tiny_decryption_algorithm
    import tea_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    input  logic         ctxt_valid,
    input  logic [63:0]  ctxt_blk,
    input  logic [127:0] key,
    output logic [63:0]  ptxt_blk,
    output logic         ptxt_ready
);

    localparam logic [5:0] CNT_LAST = 6'(NUM_ROUNDS - 1);

    tea_state_t   state;
    tea_state_t   state_next;
    logic [31:0]  v0;
    logic [31:0]  v1;
    logic [31:0]  sum;
    logic [127:0] key_reg;
    logic [5:0]   round_cnt;
    logic [31:0]  v0_next;
    logic [31:0]  v1_next;
    logic         both_valid;
    logic         load;
    logic         step;
    logic         finish;

    assign both_valid = ctxt_valid & key_valid;

    tea_round_dec u_round (
        .v0      (v0),
        .v1      (v1),
        .sum     (sum),
        .key     (key_reg),
        .v0_next (v0_next),
        .v1_next (v1_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (both_valid) begin
                    state_next = ST_RUN;
                    load       = 1'b1;
                end
            end
            ST_RUN: begin
                if (!both_valid) begin
                    state_next = ST_IDLE;
                end else begin
                    step = 1'b1;
                    if (round_cnt == CNT_LAST) begin
                        state_next = ST_DONE;
                        finish     = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (!both_valid) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0         <= 32'h0;
            v1         <= 32'h0;
            sum        <= 32'h0;
            key_reg    <= 128'h0;
            round_cnt  <= 6'd0;
            ptxt_blk   <= 64'h0;
            ptxt_ready <= 1'b0;
        end else begin
            if (load) begin
                v0        <= ctxt_blk[63:32];
                v1        <= ctxt_blk[31:0];
                key_reg   <= key;
                sum       <= DEC_SUM_INIT;
                round_cnt <= 6'd0;
            end else if (step) begin
                v0        <= v0_next;
                v1        <= v1_next;
                sum       <= sum - DELTA;
                round_cnt <= round_cnt + 6'd1;
            end
            if (finish) begin
                ptxt_blk <= {v0_next, v1_next};
            end
            ptxt_ready <= (state_next == ST_DONE);
        end
    end

`ifndef SYNTHESIS
    // Sum must have unwound exactly to zero once all rounds are done
    always @(posedge clk) begin
        if (rst_n && state == ST_DONE) begin
            assert (sum == 32'h0);
        end
        if (rst_n) begin
            assert (round_cnt <= 6'(NUM_ROUNDS));
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_tiny_decryption_algorithm.sv
// ============================================================================
// tb_tiny_decryption_algorithm : directed self-checking bench for the TEA decryptor
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_tiny_decryption_algorithm;

    localparam logic [127:0] KEY_A = 128'h80000000_00000000_00000000_00000000;
    localparam logic [63:0]  CT_A  = 64'h9327C497_31B08BBE;
    localparam logic [127:0] KEY_Z = 128'h0;
    localparam logic [63:0]  CT_Z  = 64'h41EA3A0A_94BAA940;
    localparam logic [127:0] KEY_B = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [63:0]  PT_B  = 64'h01234567_89ABCDEF;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         key_valid;
    logic         ctxt_valid;
    logic [63:0]  ctxt_blk;
    logic [127:0] key;
    logic [63:0]  ptxt_blk;
    logic         ptxt_ready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tiny_decryption_algorithm dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .ctxt_valid (ctxt_valid),
        .ctxt_blk   (ctxt_blk),
        .key        (key),
        .ptxt_blk   (ptxt_blk),
        .ptxt_ready (ptxt_ready)
    );

    // Reference TEA encryption, used to build a ciphertext from a chosen plaintext
    function automatic logic [63:0] tea_encrypt(input logic [63:0] pt, input logic [127:0] k);
        logic [31:0] a, b, s;
        a = pt[63:32];
        b = pt[31:0];
        s = 32'h0;
        for (int r = 0; r < 32; r++) begin
            s = s + 32'h9E3779B9;
            a = a + (((b << 4) + k[127:96]) ^ (b + s) ^ ((b >> 5) + k[95:64]));
            b = b + (((a << 4) + k[63:32]) ^ (a + s) ^ ((a >> 5) + k[31:0]));
        end
        return {a, b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [63:0] c, input logic [127:0] k);
        ctxt_blk   = c;
        key        = k;
        ctxt_valid = 1'b1;
        key_valid  = 1'b1;
        tick();
    endtask

    task automatic go_idle();
        ctxt_valid = 1'b0;
        key_valid  = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        key_valid  = 1'b0;
        ctxt_valid = 1'b0;
        ctxt_blk   = 64'h0;
        key        = 128'h0;
        repeat (3) tick();
        total++;
        if (ptxt_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready: got %b want 0", ptxt_ready);
        end
        total++;
        if (ptxt_blk !== 64'h0) begin
            bad++;
            $display("FAIL reset_blk: got %h want 0", ptxt_blk);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_vector_a();
        int early = 0;
        start(CT_A, KEY_A);
        for (int i = 0; i < 31; i++) begin
            tick();
            if (ptxt_ready !== 1'b0) early++;
        end
        total++;
        if (early != 0) begin
            bad++;
            $display("FAIL vec_a_early: ready high on %0d cycles want 0", early);
        end
        tick();
        total++;
        if (ptxt_ready !== 1'b1) begin
            bad++;
            $display("FAIL vec_a_latency: ready got %b want 1 at 32 clocks", ptxt_ready);
        end
        total++;
        if (ptxt_blk !== 64'h0) begin
            bad++;
            $display("FAIL vec_a_data: got %h want 0", ptxt_blk);
        end
        repeat (3) tick();
        total++;
        if (ptxt_ready !== 1'b1 || ptxt_blk !== 64'h0) begin
            bad++;
            $display("FAIL vec_a_hold: ready %b blk %h want 1 / 0", ptxt_ready, ptxt_blk);
        end
        go_idle();
        total++;
        if (ptxt_ready !== 1'b0) begin
            bad++;
            $display("FAIL vec_a_exit: ready got %b want 0", ptxt_ready);
        end
    endtask

    task automatic test_zero_key();
        start(CT_Z, KEY_Z);
        // Scramble data inputs mid-run; only the captured values may matter
        ctxt_blk = 64'hDEADBEEF_CAFEF00D;
        key      = {4{32'hA5A5A5A5}};
        repeat (32) tick();
        total++;
        if (ptxt_ready !== 1'b1 || ptxt_blk !== 64'h0) begin
            bad++;
            $display("FAIL zero_key: ready %b blk %h want 1 / 0", ptxt_ready, ptxt_blk);
        end
        go_idle();
    endtask

    task automatic test_invalid_combos();
        logic [1:0] combo;
        int hits;
        for (int c = 0; c < 3; c++) begin
            combo      = 2'(c);
            ctxt_blk   = CT_A;
            key        = KEY_A;
            ctxt_valid = combo[0];
            key_valid  = combo[1];
            hits       = 0;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (ptxt_ready !== 1'b0) hits++;
            end
            total++;
            if (hits != 0) begin
                bad++;
                $display("FAIL invalid_combo_%0d: ready high %0d cycles want 0", c, hits);
            end
        end
        go_idle();
    endtask

    task automatic test_back_to_back();
        logic [63:0] ct_b;
        int early = 0;
        ct_b = tea_encrypt(PT_B, KEY_B);
        start(CT_A, KEY_A);
        repeat (32) tick();
        total++;
        if (ptxt_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_first: ready got %b want 1", ptxt_ready);
        end
        key_valid = 1'b0;
        tick();
        total++;
        if (ptxt_ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_drop: ready got %b want 0", ptxt_ready);
        end
        start(ct_b, KEY_B);
        for (int i = 0; i < 31; i++) begin
            tick();
            if (ptxt_ready !== 1'b0) early++;
        end
        total++;
        if (early != 0) begin
            bad++;
            $display("FAIL b2b_early: ready high on %0d cycles want 0", early);
        end
        tick();
        total++;
        if (ptxt_ready !== 1'b1 || ptxt_blk !== PT_B) begin
            bad++;
            $display("FAIL b2b_second: ready %b blk %h want 1 / %h", ptxt_ready, ptxt_blk, PT_B);
        end
        go_idle();
    endtask

    task automatic test_abort();
        int hits = 0;
        start(CT_A, KEY_A);
        repeat (10) tick();
        ctxt_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ptxt_ready !== 1'b0) hits++;
        end
        total++;
        if (hits != 0) begin
            bad++;
            $display("FAIL abort_ready: ready high %0d cycles want 0", hits);
        end
        total++;
        if (ptxt_blk !== PT_B) begin
            bad++;
            $display("FAIL abort_blk: got %h want %h", ptxt_blk, PT_B);
        end
        go_idle();
    endtask

    task automatic test_reset_mid_run();
        int early = 0;
        start(CT_Z, KEY_Z);
        repeat (20) tick();
        rst_n = 1'b0;
        #1;
        total++;
        if (ptxt_ready !== 1'b0 || ptxt_blk !== 64'h0) begin
            bad++;
            $display("FAIL midrun_reset: ready %b blk %h want 0 / 0", ptxt_ready, ptxt_blk);
        end
        ctxt_valid = 1'b0;
        key_valid  = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        start(CT_A, KEY_A);
        for (int i = 0; i < 31; i++) begin
            tick();
            if (ptxt_ready !== 1'b0) early++;
        end
        tick();
        total++;
        if (early != 0 || ptxt_ready !== 1'b1 || ptxt_blk !== 64'h0) begin
            bad++;
            $display("FAIL post_reset_run: early %0d ready %b blk %h want 0 / 1 / 0",
                     early, ptxt_ready, ptxt_blk);
        end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_vector_a();
        test_zero_key();
        test_invalid_combos();
        test_back_to_back();
        test_abort();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
